data_mem_lsu: RTL and testbench
===============================

// Module: data_mem_lsu
// PURPOSE
//  Parametrised data memory for the RV32i core, successor to the flat word-wide dataMem.
//  - Adds byte/half/word(/dword) load-store with byte-lane write enables, plus sign/zero extension.
//  - Adds a valid/ready request/response handshake and optional wait states.
//  - Sits between the core's MEM stage and the data array.
// PARAMETERS
//  DATA_WIDTH   32  word width in bits; 32 or 64 only; LANES=DATA_WIDTH/8, OFS=log2(LANES)
//  ADDR_WIDTH   12  byte-address width; array depth = 2**(ADDR_WIDTH-OFS) words
//  WAIT_STATES  0   extra cycles between accept and response (0..15)
// PORTS
//  clk          in   1           clock, rising edge
//  rst_n        in   1           reset, asynchronous, active-low
//  req_valid    in   1           request present
//  req_ready    out  1           request accepted when req_valid&&req_ready
//  req_we       in   1           1=store, 0=load
//  req_size     in   2           0=byte 1=half 2=word 3=dword (legal only when DATA_WIDTH=64)
//  req_unsigned in   1           load zero-extends when 1, sign-extends when 0
//  req_addr     in   ADDR_WIDTH  byte address
//  req_wdata    in   DATA_WIDTH  store data, right-aligned (low bytes used)
//  rsp_valid    out  1           response present
//  rsp_ready    in   1           response consumed when rsp_valid&&rsp_ready
//  rsp_rdata    out  DATA_WIDTH  load data, right-aligned and extended; 0 for stores and errors
//  rsp_err      out  1           access error (see DMEM_MISALIGN_ERR_EN)
// BEHAVIOUR
//  - Reset (async): FSM=IDLE, rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter=0. The array is NOT cleared.
//  - FSM states:
//    - IDLE: req_ready=1. On accept: if WAIT_STATES==0 go to RESP, else go to WAIT with cnt=WAIT_STATES-1.
//    - WAIT: req_ready=0. cnt decrements each cycle; go to RESP when cnt==0.
//    - RESP: rsp_valid=1, req_ready=0. On rsp_ready go to IDLE. No back-to-back accept in the same cycle.
//  - Latency: rsp_valid rises WAIT_STATES+1 cycles after the accept edge.
//    - rsp_rdata and rsp_err stay stable while rsp_valid=1 and rsp_ready=0.
//  - Array access occurs at the accept edge; wait states delay only the response.
//    - Word index = req_addr[ADDR_WIDTH-1:OFS]; ofs = req_addr[OFS-1:0].
//  - Store: byte-enable mask = ((1<<(1<<size))-1)<<ofs. Write data = req_wdata<<(8*ofs). Only enabled lanes are written.
//  - Load: word>>(8*ofs), masked to 8<<size bits, then extended per req_unsigned. Dword ignores req_unsigned.
//  - Misaligned access: ofs is not a multiple of (1<<size). Handling is set by the macro below.
//  - req_size=3 with DATA_WIDTH=32: rsp_err=1, no write, rdata=0. This applies regardless of the macro.
//  - Reset mid-operation: a pending WAIT/RESP is dropped and no response is issued. A store accepted before the reset edge stays committed.
// CONFIGURATION
//  DMEM_MISALIGN_ERR_EN
//    - defined: misaligned access returns rsp_err=1 with normal latency, rdata=0, and no array write.
//    - undefined: the low log2(1<<size) address bits are forced to 0 (access is silently aligned). rsp_err is asserted only for the illegal-size case.
// TESTING
//  1. Reset with rst_n=0 -> req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0.
//  2. SW 0x100=0xDEADBEEF, then LW 0x100 -> rsp_valid 1 cycle after accept, rdata=0xDEADBEEF, err=0.
//  3. After test 2, perform these loads:
//     - LB 0x103 -> 0xFFFFFFDE
//     - LBU 0x103 -> 0x000000DE
//     - LH 0x102 -> 0xFFFFDEAD
//     - LHU 0x100 -> 0x0000BEEF
//  4. SB 0x101 wdata=0x12345655, then LW 0x100 -> 0xDEAD55EF (only lane 1 written).
//  5. WAIT_STATES=3: LW accepted at cycle T -> rsp_valid at T+4.
//     - Hold rsp_ready=0 for 2 cycles -> rdata stable and req_ready=0 throughout.
//     - Raise rsp_ready -> IDLE next cycle.
//  6. Misaligned access:
//     - With macro: LW 0x102 -> err=1, rdata=0; SW 0x102 leaves 0x100 unchanged.
//     - Without macro: LW 0x102 -> contents of 0x100, err=0.
//     - In both cases, asserting rst_n low during WAIT -> rsp_valid never rises.

Source files
------------

// File: rtl/data_mem_lsu.sv
// Byte/half/word(/dword) load-store data memory with a valid/ready handshake and optional wait states.
// Build option: DMEM_MISALIGN_ERR_EN (defined: misaligned accesses error out; undefined: silently aligned).
module data_mem_lsu #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 12,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err
);
  localparam int unsigned Lanes = DATA_WIDTH / 8;
  localparam int unsigned Ofs   = $clog2(Lanes);
  localparam int unsigned Iw    = ADDR_WIDTH - Ofs;
  localparam int unsigned Depth = 2 ** Iw;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e                state_q;
  logic [3:0]            cnt_q;
  logic [DATA_WIDTH-1:0] mem [Depth];

  logic [Iw-1:0]         idx;
  logic [Ofs-1:0]        ofs, eff_ofs, size_mask;
  logic                  legal, misal, err, accept, sbit;
  logic [Lanes-1:0]      be;
  logic [DATA_WIDTH-1:0] wdata_sh, rd_sh, ld_mask, ld_data;
  int unsigned           nbytes, nbits, ofs_n;

  assign idx       = req_addr[ADDR_WIDTH-1:Ofs];
  assign ofs       = req_addr[Ofs-1:0];
  assign req_ready = (state_q == StIdle);
  assign accept    = req_valid && req_ready;

  always_comb begin
    nbytes    = 32'd1 << req_size;
    nbits     = nbytes * 8;
    legal     = !((req_size == 2'd3) && (DATA_WIDTH == 32));
    size_mask = Ofs'(nbytes - 1);
    misal     = (ofs & size_mask) != '0;
`ifdef DMEM_MISALIGN_ERR_EN
    err       = !legal || misal;
    eff_ofs   = ofs;
`else
    err       = !legal;
    eff_ofs   = ofs & ~size_mask;
`endif
    ofs_n     = 32'(eff_ofs);
    for (int unsigned l = 0; l < Lanes; l++) begin
      be[l] = (l >= ofs_n) && (l < ofs_n + nbytes);
    end
    wdata_sh = req_wdata << {eff_ofs, 3'b000};
    rd_sh    = mem[idx] >> {eff_ofs, 3'b000};
    sbit     = 1'b0;
    for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
      ld_mask[i] = (i < nbits);
      if (i == nbits - 1) sbit = rd_sh[i];
    end
    // A full-width load has an all-ones mask, so extension is a no-op there.
    ld_data = rd_sh & ld_mask;
    if (!req_unsigned && sbit) ld_data = ld_data | ~ld_mask;
    if (err || req_we) ld_data = '0;
  end

  // The array has no reset; its contents survive rst_n.
  always_ff @(posedge clk) begin
    if (accept && req_we && !err) begin
      for (int unsigned l = 0; l < Lanes; l++) begin
        if (be[l]) mem[idx][8*l +: 8] <= wdata_sh[8*l +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= 4'd0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            rsp_rdata <= ld_data;
            rsp_err   <= err;
            if (WAIT_STATES == 0) begin
              state_q   <= StResp;
              rsp_valid <= 1'b1;
            end else begin
              state_q <= StWait;
              cnt_q   <= 4'(WAIT_STATES - 1);
            end
          end
        end
        StWait: begin
          if (cnt_q == 4'd0) begin
            state_q   <= StResp;
            rsp_valid <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        StResp: begin
          if (rsp_ready) begin
            state_q   <= StIdle;
            rsp_valid <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end
endmodule

// File: tb/tb_data_mem_lsu.sv
// Directed bench: a zero-wait instance for data paths and a 3-wait-state instance for timing/reset.
module tb_data_mem_lsu;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        a_valid = 1'b0, a_ready, a_we = 1'b0, a_uns = 1'b0;
  logic        a_rsp_valid, a_rsp_ready = 1'b0, a_err;
  logic [1:0]  a_size = 2'd0;
  logic [11:0] a_addr = '0;
  logic [31:0] a_wdata = '0, a_rdata;

  logic        w_valid = 1'b0, w_ready, w_we = 1'b0, w_uns = 1'b0;
  logic        w_rsp_valid, w_rsp_ready = 1'b0, w_err;
  logic [1:0]  w_size = 2'd0;
  logic [11:0] w_addr = '0;
  logic [31:0] w_wdata = '0, w_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  data_mem_lsu #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .WAIT_STATES(0)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(a_valid), .req_ready(a_ready), .req_we(a_we),
    .req_size(a_size), .req_unsigned(a_uns), .req_addr(a_addr), .req_wdata(a_wdata),
    .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_rdata(a_rdata), .rsp_err(a_err)
  );

  data_mem_lsu #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .WAIT_STATES(3)) dut_w (
    .clk(clk), .rst_n(rst_n), .req_valid(w_valid), .req_ready(w_ready), .req_we(w_we),
    .req_size(w_size), .req_unsigned(w_uns), .req_addr(w_addr), .req_wdata(w_wdata),
    .rsp_valid(w_rsp_valid), .rsp_ready(w_rsp_ready), .rsp_rdata(w_rdata), .rsp_err(w_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic acc_a(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [11:0] ad, input logic [31:0] wd,
                       output logic [31:0] rd, output logic er, output int lat);
    @(negedge clk);
    a_valid = 1'b1; a_we = we; a_size = sz; a_uns = uns; a_addr = ad; a_wdata = wd;
    @(negedge clk);
    a_valid = 1'b0;
    lat = 1;
    while (!a_rsp_valid && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    rd = a_rdata;
    er = a_err;
    a_rsp_ready = 1'b1;
    @(negedge clk);
    a_rsp_ready = 1'b0;
  endtask

  task automatic ld_a(input string tag, input logic [1:0] sz, input logic uns,
                      input logic [11:0] ad, input logic [31:0] exp_d, input logic exp_e);
    logic [31:0] rd;
    logic        er;
    int          lat;
    acc_a(1'b0, sz, uns, ad, 32'h0, rd, er, lat);
    check({tag, " latency"}, 32'(lat), 32'd1);
    check({tag, " rdata"}, rd, exp_d);
    check({tag, " err"}, {31'b0, er}, {31'b0, exp_e});
  endtask

  task automatic st_a(input string tag, input logic [1:0] sz, input logic [11:0] ad,
                      input logic [31:0] wd, input logic exp_e);
    logic [31:0] rd;
    logic        er;
    int          lat;
    acc_a(1'b1, sz, 1'b0, ad, wd, rd, er, lat);
    check({tag, " latency"}, 32'(lat), 32'd1);
    check({tag, " rdata"}, rd, 32'h0);
    check({tag, " err"}, {31'b0, er}, {31'b0, exp_e});
  endtask

  initial begin
    int   lat;
    logic rdy_ok, seen;

    repeat (2) @(negedge clk);
    check("rst req_ready", {31'b0, a_ready}, 32'd1);
    check("rst rsp_valid", {31'b0, a_rsp_valid}, 32'd0);
    check("rst rsp_rdata", a_rdata, 32'h0);
    check("rst rsp_err", {31'b0, a_err}, 32'd0);
    rst_n = 1'b1;

    st_a("sw_100", 2'd2, 12'h100, 32'hDEADBEEF, 1'b0);
    ld_a("lw_100", 2'd2, 1'b0, 12'h100, 32'hDEADBEEF, 1'b0);
    ld_a("lb_103", 2'd0, 1'b0, 12'h103, 32'hFFFFFFDE, 1'b0);
    ld_a("lbu_103", 2'd0, 1'b1, 12'h103, 32'h000000DE, 1'b0);
    ld_a("lh_102", 2'd1, 1'b0, 12'h102, 32'hFFFFDEAD, 1'b0);
    ld_a("lhu_100", 2'd1, 1'b1, 12'h100, 32'h0000BEEF, 1'b0);
    st_a("sb_101", 2'd0, 12'h101, 32'h12345655, 1'b0);
    ld_a("lw_after_sb", 2'd2, 1'b0, 12'h100, 32'hDEAD55EF, 1'b0);

    // top-of-array boundary
    st_a("sw_ffc", 2'd2, 12'hFFC, 32'h80000001, 1'b0);
    ld_a("lw_ffc", 2'd2, 1'b0, 12'hFFC, 32'h80000001, 1'b0);
    ld_a("lh_ffe", 2'd1, 1'b0, 12'hFFE, 32'hFFFF8000, 1'b0);
    ld_a("lbu_fff", 2'd0, 1'b1, 12'hFFF, 32'h00000080, 1'b0);
    ld_a("lb_ffc", 2'd0, 1'b0, 12'hFFC, 32'h00000001, 1'b0);

    // dword on a 32-bit array is always an error and never writes
    ld_a("ld_100", 2'd3, 1'b0, 12'h100, 32'h0, 1'b1);
    st_a("sd_100", 2'd3, 12'h100, 32'h0, 1'b1);
    ld_a("lw_after_sd", 2'd2, 1'b0, 12'h100, 32'hDEAD55EF, 1'b0);

`ifdef DMEM_MISALIGN_ERR_EN
    ld_a("lw_102_mis", 2'd2, 1'b0, 12'h102, 32'h0, 1'b1);
    ld_a("lh_101_mis", 2'd1, 1'b0, 12'h101, 32'h0, 1'b1);
    st_a("sw_102_mis", 2'd2, 12'h102, 32'h11223344, 1'b1);
    ld_a("lw_after_mis", 2'd2, 1'b0, 12'h100, 32'hDEAD55EF, 1'b0);
`else
    ld_a("lw_102_mis", 2'd2, 1'b0, 12'h102, 32'hDEAD55EF, 1'b0);
    ld_a("lh_101_mis", 2'd1, 1'b0, 12'h101, 32'h000055EF, 1'b0);
    st_a("sw_102_mis", 2'd2, 12'h102, 32'h11223344, 1'b0);
    ld_a("lw_after_mis", 2'd2, 1'b0, 12'h100, 32'h11223344, 1'b0);
`endif

    // wait-state instance: store, then timed load
    @(negedge clk);
    w_valid = 1'b1; w_we = 1'b1; w_size = 2'd2; w_addr = 12'h040; w_wdata = 32'hCAFEF00D;
    @(negedge clk);
    w_valid = 1'b0;
    lat = 1;
    while (!w_rsp_valid && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    check("ws sw latency", 32'(lat), 32'd4);
    check("ws sw err", {31'b0, w_err}, 32'd0);
    w_rsp_ready = 1'b1;
    @(negedge clk);
    w_rsp_ready = 1'b0;

    w_valid = 1'b1; w_we = 1'b0; w_size = 2'd2; w_addr = 12'h040;
    @(negedge clk);
    w_valid = 1'b0;
    lat = 1;
    rdy_ok = 1'b1;
    while (!w_rsp_valid && lat < 30) begin
      if (w_ready) rdy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    check("ws lw latency", 32'(lat), 32'd4);
    check("ws req_ready low in wait", {31'b0, rdy_ok}, 32'd1);
    check("ws lw rdata", w_rdata, 32'hCAFEF00D);
    repeat (2) begin
      @(negedge clk);
      check("ws hold rdata", w_rdata, 32'hCAFEF00D);
      check("ws hold rsp_valid", {31'b0, w_rsp_valid}, 32'd1);
      check("ws hold req_ready", {31'b0, w_ready}, 32'd0);
    end
    w_rsp_ready = 1'b1;
    @(negedge clk);
    w_rsp_ready = 1'b0;
    check("ws release rsp_valid", {31'b0, w_rsp_valid}, 32'd0);
    check("ws release req_ready", {31'b0, w_ready}, 32'd1);

    // reset while waiting drops the response
    w_valid = 1'b1; w_we = 1'b0; w_addr = 12'h040;
    @(negedge clk);
    w_valid = 1'b0;
    check("ws in wait req_ready", {31'b0, w_ready}, 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (w_rsp_valid) seen = 1'b1;
    end
    check("ws reset drops rsp", {31'b0, seen}, 32'd0);
    check("ws reset req_ready", {31'b0, w_ready}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
